// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
// Holds XLEN, reset PC, the NOP encoding and the fetch queue entry type.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            data_ready;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(
    input logic [XLEN-1:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between IF and imem.
// master = fetch stage, slave = memory.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry in-order fetch queue: allocate on accept, fill on response,
// pop on consume, flush on redirect. Data always fills the oldest pending slot.
module fetch_queue
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output fetch_entry_t    head,
  output logic [1:0]      count,
  output logic [1:0]      pending
);

  fetch_entry_t ent [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt_q;
  logic [1:0]   vld;
  logic         fill_ptr;
  logic         fill_ok;

  // Occupancy, missing-data count and the slot the next response lands in
  always_comb begin
    vld[0]   = (cnt_q == 2'd2) || (cnt_q == 2'd1 && !rd_ptr);
    vld[1]   = (cnt_q == 2'd2) || (cnt_q == 2'd1 && rd_ptr);
    pending  = {1'b0, vld[0] && !ent[0].data_ready}
             + {1'b0, vld[1] && !ent[1].data_ready};
    fill_ptr = (vld[rd_ptr] && !ent[rd_ptr].data_ready)
             ? rd_ptr : ~rd_ptr;
    fill_ok  = fill && (pending != 2'd0);
  end

  // Entry storage, pointers and count; flush beats every other update
  always_ff @(posedge clk) begin
    if (rst) begin
      ent[0] <= '0;
      ent[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (flush) begin
      ent[0].data_ready <= 1'b0;
      ent[1].data_ready <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (alloc) begin
        ent[wr_ptr] <= '{pc: alloc_pc,
                         instr: '0,
                         data_ready: 1'b0};
        wr_ptr <= ~wr_ptr;
      end
      if (fill_ok) begin
        ent[fill_ptr].instr      <= fill_data;
        ent[fill_ptr].data_ready <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt_q <= cnt_q + {1'b0, alloc} - {1'b0, pop};
    end
  end

  assign head  = ent[rd_ptr];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, imem handshake, redirect discard.
// Optional FETCH_PERF_EN adds the fetch_bubble_cnt performance counter.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fetch_stage_if.master   imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_bubble_cnt
`endif
);

  logic [XLEN-1:0] pc_q;
  logic [1:0]      discard_cnt;
  logic [1:0]      discard_d;
  logic [2:0]      owed;
  fetch_entry_t    head;
  logic [1:0]      count;
  logic [1:0]      pending;
  logic            accept;
  logic            drop;
  logic            fill;
  logic            pop;

  assign imem.imem_req  = !rst && !redirect_valid
                        && (count < 2'd2);
  assign imem.imem_addr = pc_q;

  assign accept = imem.imem_req && imem.imem_ready;
  assign drop   = imem.imem_rvalid && (discard_cnt != 2'd0);
  assign fill   = imem.imem_rvalid && (discard_cnt == 2'd0)
                && !redirect_valid;
  assign pop    = if_valid && !stall;

  fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .alloc     (accept),
    .alloc_pc  (pc_q),
    .fill      (fill),
    .fill_data (imem.imem_rdata),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .pending   (pending)
  );

  assign if_valid = (count != 2'd0) && head.data_ready;
  assign if_pc    = head.pc;
  assign if_instr = if_valid ? head.instr : NOP_INSTR;

  // Responses still owed to dead requests once a redirect flushes the queue
  always_comb begin
    owed = {1'b0, discard_cnt} + {1'b0, pending};
    if (imem.imem_rvalid && owed != 3'd0) begin
      owed = owed - 3'd1;
    end
    discard_d = discard_cnt;
    if (redirect_valid) begin
      discard_d = (owed > 3'd2) ? 2'd2 : owed[1:0];
    end else if (drop) begin
      discard_d = discard_cnt - 2'd1;
    end
  end

  // Program counter and discard counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      discard_cnt <= 2'd0;
    end else begin
      discard_cnt <= discard_d;
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (accept) begin
        pc_q <= pc_next(pc_q);
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Count cycles where IF/ID would capture a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_bubble_cnt <= 32'd0;
    end else if (!stall && !if_valid) begin
      fetch_bubble_cnt <= fetch_bubble_cnt + 32'd1;
    end
  end
`endif

  // A response must belong to some outstanding request
  rvalid_has_owner: assert property (
    @(posedge clk) disable iff (rst)
    imem.imem_rvalid |-> (discard_cnt != 2'd0 || pending != 2'd0)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a queue-based imem model
// and an in-order instruction stream reference.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] bub_cnt;
`endif

  fetch_stage_if m();

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (m),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_PERF_EN
    ,
    .fetch_bubble_cnt (bub_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          total;
  int          passed;
  int          cyc;
  int          ready_mode;
  int          resp_mode;
  int          bub;
  int          acc_cnt;
  int          first_acc;
  int          first_val;
  int          base;
  logic [31:0] memq [$];
  logic [31:0] pops [$];
  logic [31:0] exp_pc;
  logic [31:0] fetch_pc;
  logic [31:0] last_acc;
  logic        prev_hold;
  logic        saw_wrap;
  logic        last_req;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    if (pops.size() > i) return pops[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive_mem();
    logic rv;
    case (ready_mode)
      0:       m.imem_ready = 1'b0;
      1:       m.imem_ready = 1'b1;
      default: m.imem_ready = ($urandom_range(0, 9) < 7);
    endcase
    rv = (memq.size() > 0) &&
         (resp_mode == 1 ||
          (resp_mode == 2 && $urandom_range(0, 9) < 6));
    m.imem_rvalid = rv;
    m.imem_rdata  = rv ? memf(memq[0]) : $urandom;
  endtask

  task automatic cycle();
    logic        acc;
    logic        resp;
    logic        pop;
    logic [31:0] addr;
    drive_mem();
    @(negedge clk);
    cyc++;
    acc      = m.imem_req && m.imem_ready;
    resp     = m.imem_rvalid;
    addr     = m.imem_addr;
    pop      = if_valid && !stall && !redirect_valid;
    last_req = m.imem_req;
    if (rst) begin
      chk("req_in_rst", 32'(m.imem_req), 32'd0);
    end else begin
      if (if_valid) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", if_instr, memf(exp_pc));
        if (first_val < 0) first_val = cyc;
      end else begin
        chk("nop_idle", if_instr, NOP_INSTR);
      end
      if (redirect_valid)
        chk("req_on_redirect", 32'(m.imem_req), 32'd0);
      if (m.imem_req)
        chk("imem_addr", addr, fetch_pc);
      if (prev_hold && !redirect_valid)
        chk("req_held", 32'(m.imem_req), 32'd1);
      if (acc) begin
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        if (addr == 32'h0 && last_acc == 32'hFFFF_FFFC)
          saw_wrap = 1'b1;
        last_acc = addr;
      end
      if (pop) pops.push_back(if_pc);
      if (!stall && !if_valid) bub++;
    end
    prev_hold = !rst && m.imem_req && !m.imem_ready
              && !redirect_valid;
    if (rst) begin
      exp_pc   = RESET_PC;
      fetch_pc = RESET_PC;
      bub      = 0;
    end else begin
      if (pop) exp_pc = exp_pc + 32'd4;
      if (redirect_valid) begin
        exp_pc   = redirect_pc;
        fetch_pc = redirect_pc;
      end else if (acc) begin
        fetch_pc = fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      memq.delete();
    end else begin
      if (resp) void'(memq.pop_front());
      if (acc) memq.push_back(addr);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic make_two_outstanding();
    ready_mode = 0;
    resp_mode  = 1;
    run(4);
    ready_mode = 1;
    resp_mode  = 0;
    run(3);
    chk("outstanding_two", 32'(memq.size()), 32'd2);
  endtask

  initial begin
    total = 0; passed = 0; cyc = 0; bub = 0;
    acc_cnt = 0; first_acc = -1; first_val = -1;
    rst = 1'b1; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    ready_mode = 0; resp_mode = 0;
    exp_pc = RESET_PC; fetch_pc = RESET_PC;
    last_acc = 32'h0; prev_hold = 1'b0;
    saw_wrap = 1'b0; last_req = 1'b0;
    m.imem_ready = 1'b0; m.imem_rvalid = 1'b0;
    m.imem_rdata = 32'h0;

    // reset state
    run(3);
    chk("rst_req", 32'(m.imem_req), 32'd0);
    chk("rst_addr", m.imem_addr, RESET_PC);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, NOP_INSTR);
    chk("rst_discard", 32'(dut.discard_cnt), 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_bubble", bub_cnt, 32'd0);
`endif

    // streaming with 1-cycle memory
    rst = 1'b0;
    ready_mode = 1; resp_mode = 1;
    first_acc = -1; first_val = -1;
    base = cyc + 1;
    pops.delete();
    run(10);
    chk("first_accept_cycle", 32'(first_acc), 32'(base));
    chk("valid_latency", 32'(first_val - first_acc), 32'd2);
    chk("stream_pc0", pop_at(0), 32'h0);
    chk("stream_pc1", pop_at(1), 32'h4);
    chk("stream_pc2", pop_at(2), 32'h8);

    // stall held for 5 cycles
    stall = 1'b1;
    acc_cnt = 0;
    run(5);
    chk("stall_accepts_le2", 32'(acc_cnt <= 2), 32'd1);
    chk("stall_req_low", 32'(last_req), 32'd0);
    stall = 1'b0;
    run(8);

    // redirect with two outstanding
    make_two_outstanding();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    run(1);
    redirect_valid = 1'b0;
    chk("discard_two", 32'(dut.discard_cnt), 32'd2);
    ready_mode = 1; resp_mode = 1;
    pops.delete();
    run(10);
    chk("redir_pc0", pop_at(0), 32'h100);
    chk("redir_pc1", pop_at(1), 32'h104);

    // redirect together with a response
    make_two_outstanding();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    resp_mode      = 1;
    run(1);
    redirect_valid = 1'b0;
    chk("discard_one", 32'(dut.discard_cnt), 32'd1);
    pops.delete();
    run(10);
    chk("redir2_pc0", pop_at(0), 32'h200);
    chk("redir2_pc1", pop_at(1), 32'h204);

    // memory not ready for 3 cycles
    ready_mode = 0;
    run(3);
    acc_cnt = 0;
    run(3);
    chk("no_accept_unready", 32'(acc_cnt), 32'd0);
    chk("req_stays_high", 32'(last_req), 32'd1);
    ready_mode = 1;
    run(4);

    // PC wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    run(1);
    redirect_valid = 1'b0;
    saw_wrap = 1'b0;
    pops.delete();
    run(12);
    chk("wrap_seen", 32'(saw_wrap), 32'd1);
    chk("wrap_pc0", pop_at(0), 32'hFFFF_FFF8);
    chk("wrap_pc1", pop_at(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", pop_at(2), 32'h0000_0000);
    chk("wrap_pc3", pop_at(3), 32'h0000_0004);

    // randomized traffic with a mid-run reset
    ready_mode = 2; resp_mode = 2;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      rst   = (i >= 200 && i < 202);
      stall = ($urandom_range(0, 9) < 3);
      redirect_valid = !rst && (memq.size() <= 2)
                     && ($urandom_range(0, 19) == 0);
      redirect_pc = r & 32'hFFFF_FFFC;
      cycle();
    end
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    ready_mode = 1; resp_mode = 1;
    run(6);
`ifdef FETCH_PERF_EN
    chk("bubble_cnt", bub_cnt, 32'(bub));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
